// File: rtl/pipeline_sequencer.sv
// Run/halt/single-step controller and load-use/branch hazard sequencer for the
// five-stage pipeline, with saturating cycle, stall and flush counters.
module pipeline_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             clear_cnt,
  input  logic             memread_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             branch_taken_mem,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic load_use;
  logic stall_ev;
  logic flush_ev;

  localparam logic [CNT_W-1:0] CntMax = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHalt;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt: begin
        if (halt_req)      state_d = StHalt;
        else if (run_req)  state_d = StRun;
        else if (step_req) state_d = StStep;
      end
      StRun:   if (halt_req) state_d = StHalt;
      StStep:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  assign load_use = memread_ex && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

  always_comb begin
    pipe_en      = (state_q == StRun) || (state_q == StStep);
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (pipe_en) begin
      // A taken branch discards the stalled instruction, so it beats load-use.
      if (branch_taken_mem) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else if (load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  assign stall_ev = pipe_en && !branch_taken_mem && load_use;
  assign flush_ev = pipe_en && branch_taken_mem;
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clear_cnt) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pipe_en && (cycle_cnt != CntMax)) cycle_cnt <= cycle_cnt + 1'b1;
      if (stall_ev && (stall_cnt != CntMax)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && (flush_cnt != CntMax)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; a second instance with 4-bit counters
// shares the stimulus to exercise saturation.
module tb_pipeline_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run_req, halt_req, step_req, clear_cnt;
  logic        memread_ex, branch_taken_mem;
  logic [4:0]  rt_ex, rs_id, rt_id;

  logic        pipe_en, pc_write, if_id_write, id_ex_bubble;
  logic        flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0]  state;
  logic [15:0] cycle_cnt, stall_cnt, flush_cnt;

  logic        pipe_en4, pc_write4, if_id_write4, id_ex_bubble4;
  logic        flush_if_id4, flush_id_ex4, flush_ex_mem4;
  logic [1:0]  state4;
  logic [3:0]  cycle_cnt4, stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  pipeline_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .clear_cnt(clear_cnt), .memread_ex(memread_ex),
    .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id), .branch_taken_mem(branch_taken_mem),
    .pipe_en(pipe_en), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .state(state), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .clear_cnt(clear_cnt), .memread_ex(memread_ex),
    .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id), .branch_taken_mem(branch_taken_mem),
    .pipe_en(pipe_en4), .pc_write(pc_write4), .if_id_write(if_id_write4),
    .id_ex_bubble(id_ex_bubble4), .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4),
    .flush_ex_mem(flush_ex_mem4), .state(state4), .cycle_cnt(cycle_cnt4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then let outputs settle before anything is checked.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run_req = 0; halt_req = 0; step_req = 0; clear_cnt = 0;
    memread_ex = 0; branch_taken_mem = 0; rt_ex = 0; rs_id = 0; rt_id = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic enter_run();
    run_req = 1;
    tick();
    run_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    checks++;
    if (state !== 2'b00 || pipe_en !== 1'b0 || pc_write !== 1'b0 || if_id_write !== 1'b0 ||
        id_ex_bubble !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 ||
        flush_ex_mem !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%b pipe_en=%b pc_write=%b ifid=%b bubble=%b, want all 0",
               state, pipe_en, pc_write, if_id_write, id_ex_bubble);
    end
    checks++;
    if (cycle_cnt !== 16'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: %0d %0d %0d, want 0 0 0", cycle_cnt, stall_cnt, flush_cnt);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (state !== 2'b00 || pipe_en !== 1'b0 || cycle_cnt !== 16'd0) begin
        errors++;
        $display("FAIL idle_halt cyc%0d: state=%b pipe_en=%b cycle_cnt=%0d, want 00 0 0",
                 i, state, pipe_en, cycle_cnt);
      end
    end
    enter_run();
    tick();
    tick();
    checks++;
    if (state !== 2'b01 || cycle_cnt !== 16'd2) begin
      errors++;
      $display("FAIL run_before_reset: state=%b cycle_cnt=%0d, want 01 2", state, cycle_cnt);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (state !== 2'b00 || pipe_en !== 1'b0 || cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: state=%b pipe_en=%b cycle_cnt=%0d, want 00 0 0",
               state, pipe_en, cycle_cnt);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    enter_run();
    memread_ex = 1; rt_ex = 5'd5; rs_id = 5'd5; rt_id = 5'd0;
    #1;
    checks++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0 || id_ex_bubble !== 1'b1 ||
        flush_id_ex !== 1'b0) begin
      errors++;
      $display("FAIL load_use_rs: pc_write=%b ifid=%b bubble=%b flush=%b, want 0 0 1 0",
               pc_write, if_id_write, id_ex_bubble, flush_id_ex);
    end
    tick();
    idle_inputs();
    checks++;
    if (stall_cnt !== 16'd1 || cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stall_cnt_1: stall=%0d cycle=%0d, want 1 1", stall_cnt, cycle_cnt);
    end
    memread_ex = 1; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    #1;
    checks++;
    if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL rt_zero_no_stall: pc_write=%b ifid=%b bubble=%b, want 1 1 0",
               pc_write, if_id_write, id_ex_bubble);
    end
    tick();
    memread_ex = 1; rt_ex = 5'd7; rs_id = 5'd3; rt_id = 5'd7;
    #1;
    checks++;
    if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL load_use_rt: bubble=%b pc_write=%b, want 1 0", id_ex_bubble, pc_write);
    end
    memread_ex = 0;
    #1;
    checks++;
    if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL no_memread: bubble=%b pc_write=%b, want 0 1", id_ex_bubble, pc_write);
    end
    memread_ex = 1;
    tick();
    idle_inputs();
    checks++;
    if (stall_cnt !== 16'd2 || cycle_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_cnt_2: stall=%0d cycle=%0d, want 2 3", stall_cnt, cycle_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken_mem = 1; memread_ex = 1; rt_ex = 5'd9; rs_id = 5'd9;
    #1;
    checks++;
    if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || flush_ex_mem !== 1'b0 ||
        pc_write !== 1'b0 || id_ex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL branch_in_halt: flushes=%b%b%b pc_write=%b bubble=%b, want 000 0 0",
               flush_if_id, flush_id_ex, flush_ex_mem, pc_write, id_ex_bubble);
    end
    idle_inputs();
    enter_run();
    branch_taken_mem = 1; memread_ex = 1; rt_ex = 5'd9; rs_id = 5'd9;
    #1;
    checks++;
    if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 || flush_ex_mem !== 1'b1 ||
        pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL branch_over_load_use: flushes=%b%b%b pc=%b ifid=%b bubble=%b, want 111 1 1 0",
               flush_if_id, flush_id_ex, flush_ex_mem, pc_write, if_id_write, id_ex_bubble);
    end
    tick();
    idle_inputs();
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL branch_counts: flush=%0d stall=%0d, want 1 0", flush_cnt, stall_cnt);
    end
    halt_req = 1;
    tick();
    halt_req = 0;
    checks++;
    if (state !== 2'b00 || pipe_en !== 1'b0 || cycle_cnt !== 16'd2) begin
      errors++;
      $display("FAIL halt_from_run: state=%b pipe_en=%b cycle=%0d, want 00 0 2",
               state, pipe_en, cycle_cnt);
    end
  endtask

  task automatic test_step();
    do_reset();
    step_req = 1;
    tick();
    step_req = 0;
    checks++;
    if (state !== 2'b10 || pipe_en !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL step_active: state=%b pipe_en=%b pc_write=%b, want 10 1 1",
               state, pipe_en, pc_write);
    end
    tick();
    checks++;
    if (state !== 2'b00 || pipe_en !== 1'b0 || cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL step_done: state=%b pipe_en=%b cycle=%0d, want 00 0 1",
               state, pipe_en, cycle_cnt);
    end
    halt_req = 1; run_req = 1; step_req = 1;
    tick();
    idle_inputs();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL halt_priority: state=%b, want 00", state);
    end
    run_req = 1; step_req = 1;
    tick();
    idle_inputs();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL run_over_step: state=%b, want 01", state);
    end
    do_reset();
    step_req = 1;
    tick();
    step_req = 0;
    run_req = 1;
    memread_ex = 1; rt_ex = 5'd4; rs_id = 5'd4;
    #1;
    checks++;
    if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL step_load_use: bubble=%b pc_write=%b, want 1 0", id_ex_bubble, pc_write);
    end
    tick();
    idle_inputs();
    checks++;
    if (state !== 2'b00 || stall_cnt !== 16'd1 || cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL step_ignores_req: state=%b stall=%0d cycle=%0d, want 00 1 1",
               state, stall_cnt, cycle_cnt);
    end
    step_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== ((i % 2 == 0) ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL held_step cyc%0d: state=%b, want %b", i, state,
                 (i % 2 == 0) ? 2'b10 : 2'b00);
      end
    end
    step_req = 0;
    checks++;
    if (cycle_cnt !== 16'd3) begin
      errors++;
      $display("FAIL held_step_cycles: cycle=%0d, want 3", cycle_cnt);
    end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    enter_run();
    run_req = 1;
    for (int i = 0; i < 20; i++) tick();
    run_req = 0;
    checks++;
    if (cycle_cnt4 !== 4'd15 || cycle_cnt !== 16'd20 || state4 !== 2'b01) begin
      errors++;
      $display("FAIL saturate: cnt4=%0d cnt16=%0d state4=%b, want 15 20 01",
               cycle_cnt4, cycle_cnt, state4);
    end
    memread_ex = 1; rt_ex = 5'd2; rt_id = 5'd2;
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd17) begin
      errors++;
      $display("FAIL stall_saturate: stall4=%0d stall16=%0d, want 15 17", stall_cnt4, stall_cnt);
    end
    clear_cnt = 1;
    #1;
    checks++;
    if (id_ex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL clear_cycle_stall: bubble=%b, want 1", id_ex_bubble);
    end
    tick();
    clear_cnt = 0;
    checks++;
    if (stall_cnt !== 16'd0 || cycle_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
      errors++;
      $display("FAIL clear_priority: stall=%0d cycle=%0d stall4=%0d, want 0 0 0",
               stall_cnt, cycle_cnt, stall_cnt4);
    end
    tick();
    idle_inputs();
    checks++;
    if (stall_cnt !== 16'd1 || cycle_cnt !== 16'd1) begin
      errors++;
      $display("FAIL after_clear: stall=%0d cycle=%0d, want 1 1", stall_cnt, cycle_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_step();
    test_saturate_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run/halt/single-step controller and hazard sequencer for the five-stage MIPS pipeline. Sits beside the datapath. Generates the global pipeline enable, load-use stall controls (PC/IF_ID hold, ID_EX bubble) and branch-taken flushes for IF_ID, ID_EX and EX_MEM. Keeps saturating performance counters for cycles, stalls and flushes.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- run_req  in  1  enter free-run from HALT
- halt_req  in  1  stop the pipeline
- step_req  in  1  advance exactly one cycle from HALT
- clear_cnt  in  1  synchronous clear of all counters
- memread_ex  in  1  MemRead of instruction in EX
- rt_ex  in  5  destination rt of instruction in EX (instruction_EX[20:16])
- rs_id  in  5  instruction_ID[25:21]
- rt_id  in  5  instruction_ID[20:16]
- branch_taken_mem  in  1  Zero_MEM & Branch_MEM
- pipe_en  out  1  enable for PC and all four pipeline registers
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF_ID load enable
- id_ex_bubble  out  1  force all ID_EX control bits to 0
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear control bits of that register on the next edge
- state  out  2  00 HALT, 01 RUN, 10 STEP
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- FSM with states HALT, RUN and STEP. Transitions:
  - HALT: halt_req → HALT; else run_req → RUN; else step_req → STEP.
  - RUN: halt_req → HALT; else stay in RUN.
  - STEP: always → HALT next cycle; requests ignored.
  - Priority when requests coincide: halt > run > step.
- pipe_en = 1 in RUN and STEP, 0 in HALT.
- load_use = memread_ex & (rt_ex != 0) & ((rt_ex == rs_id) | (rt_ex == rt_id)).
- When pipe_en = 0, all hazard and flush outputs are 0:
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 0.
  - Datapath holds because pipe_en = 0.
- When pipe_en = 1 and branch_taken_mem = 1:
  - Assert all three flushes.
  - pc_write = 1, if_id_write = 1, id_ex_bubble = 0.
  - Branch overrides load_use, since the stalled instruction is being discarded.
- When pipe_en = 1, no branch, and load_use = 1: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
- Otherwise pc_write = 1, if_id_write = 1, bubble = 0, flushes = 0.
- Counters:
  - cycle_cnt increments on each cycle with pipe_en = 1.
  - stall_cnt increments on each cycle with pipe_en & ~branch_taken_mem & load_use.
  - flush_cnt increments on each cycle with pipe_en & branch_taken_mem.
  - All counters saturate at 2^CNT_W-1.
  - clear_cnt has priority over increment: the counter becomes 0 even if an increment event occurs in that cycle.
- A single step taken during a load-use condition produces the bubble and consumes the step. The next step completes the held instruction.

## Timing
- Reset values: state = HALT, pipe_en = 0, pc_write = 0, if_id_write = 0, id_ex_bubble = 0, all flushes = 0, all counters = 0.
- Reset is asynchronous. Asserting it mid-RUN forces HALT and zeros the counters immediately.
- FSM and counters update on the rising edge of clk.
- pipe_en, pc_write, if_id_write, bubble and flushes are combinational from the registered state and the current inputs. Zero-cycle latency is needed so the datapath reacts in the same cycle the hazard is visible.
- Request latency: a request sampled at edge N changes state and pipe_en after edge N.
- STEP lasts exactly one cycle, so pipe_en is high for one cycle per step_req accepted in HALT.
- A request held high is re-evaluated every cycle:
  - step_req held high in HALT yields alternating STEP/HALT, one advance every 2 cycles.
  - run_req held high is idempotent.

## Test plan
- Reset, then release rst_n with no requests → state = 00, pipe_en = 0, all counters 0 for 10 cycles. Assert rst_n low mid-RUN → state = 00 asynchronously, before the next edge.
- run_req pulse, then memread_ex = 1, rt_ex = 5, rs_id = 5 for one cycle → pc_write = 0, if_id_write = 0, id_ex_bubble = 1 in that cycle; stall_cnt = 1 afterwards. Same test with rt_ex = 0 → no stall.
- In RUN, branch_taken_mem = 1 together with load_use = 1 → all flushes = 1, pc_write = 1, bubble = 0; flush_cnt += 1, stall_cnt unchanged.
- In HALT, step_req pulse → exactly one cycle of pipe_en = 1 with state = 10, then state = 00; cycle_cnt = 1. Simultaneous halt_req + run_req in HALT → stays in HALT.
- CNT_W = 4, run 20 cycles → cycle_cnt saturates at 15. clear_cnt asserted during a stall cycle → stall_cnt = 0 on the next edge.
